pea_result_drain: RTL
=====================

// Module: pea_result_drain
// PURPOSE
//  Downstream drain for the PEA output stage. Pops the paired result/status
//  output FIFOs (both 32 bit, written together by the PEA wr_out strobe).
//  Serializes each pair into four 16-bit words on a valid/ready host port.
//  Keeps packet/error counters and a sticky FIFO-desync flag.
// PARAMETERS
//  buffer_size_out  32  depth of each output FIFO; pop ports are log2(buffer_size_out) bits
//  width            16  host word width; FIFO words are 2*width
// PORTS
//  clk         in   1         system clock, rising edge
//  rst         in   1         asynchronous, active-low reset
//  result_pop  in   log2(B)   occupancy of result FIFO
//  status_pop  in   log2(B)   occupancy of status FIFO
//  result_in   in   2*width   result FIFO read data (valid the cycle after rd_en)
//  status_in   in   2*width   status FIFO read data (valid the cycle after rd_en)
//  rd_en       out  1         pop strobe, drives both FIFO read enables
//  out_data    out  width     host word
//  out_valid   out  1         out_data valid
//  out_ready   in   1         host accepts word when out_valid & out_ready
//  pkt_count   out  16        packets fully sent; wraps at 2^16
//  err_count   out  16        packets with status_in != 0; saturates at 16'hFFFF
//  sync_err    out  1         sticky; result_pop != status_pop seen in IDLE
//  busy        out  1         high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, rst=0)
//   - state=IDLE; rd_en=0, out_valid=0, out_data=0
//   - pkt_count=0, err_count=0, sync_err=0; holding regs cleared
//   - Reset mid-packet discards the in-flight packet. Its FIFO entry is already
//     consumed and is not recovered.
//  FSM: IDLE -> POP -> LATCH -> SEND0 -> SEND1 -> SEND2 -> SEND3 -> IDLE
//   - IDLE:  go to POP when result_pop!=0 && status_pop!=0.
//            If result_pop!=status_pop, set sync_err (sticky until reset).
//            If only one FIFO is non-empty, stay in IDLE. Never pop one FIFO alone.
//   - POP:   rd_en=1 for exactly one cycle (combinational decode of state); go to LATCH.
//   - LATCH: register result_in/status_in into holding regs.
//            If status_in!=0, err_count+1 (saturating). Go to SEND0.
//   - SENDk: out_valid=1. Word order:
//            SEND0 = status[31:16], SEND1 = status[15:0],
//            SEND2 = result[31:16], SEND3 = result[15:0].
//            Advance only on out_valid & out_ready.
//            On the SEND3 handshake, pkt_count+1 and go to IDLE.
//  Handshake rules
//   - While out_valid=1 and out_ready=0, out_data is held stable.
//   - out_valid is never withdrawn before acceptance.
//   - out_data and out_valid are registered outputs.
//  Latency and throughput
//   - Both pops become nonzero at cycle t: rd_en at t+1, first word valid at t+3.
//   - With out_ready held at 1, each packet takes 7 cycles: 4 word cycles, 1 IDLE, POP, LATCH.
//  Boundary conditions
//   - rd_en is never asserted when either pop count is 0 in the IDLE decision cycle.
//   - A FIFO write arriving during SENDk is ignored until the return to IDLE.
//   - Counters update independently; the err_count increment (LATCH) and the
//     pkt_count increment (SEND3) never occur in the same cycle.
// TESTING
//  1. Reset: hold rst=0 with pops nonzero -> rd_en=0, out_valid=0, all counters 0, sync_err=0.
//  2. Single pair: result=32'h0000_0019, status=0, pops 0->1, out_ready=1
//     -> words 0000,0000,0000,0019 on cycles t+3..t+6; pkt_count=1, err_count=0; exactly one rd_en pulse.
//  3. Backpressure: status=32'hDEAD_BEEF, result=32'h1234_5678, out_ready low for 5 cycles in SEND1
//     -> BEEF held stable 6 cycles; order DEAD,BEEF,1234,5678; err_count=1.
//  4. Back-to-back: pops=3, out_ready=1 -> 12 words in 3 groups; rd_en pulses 7 cycles apart; pkt_count=3.
//  5. Desync: result_pop=1, status_pop=0 for 10 cycles -> no rd_en, sync_err=1;
//     status_pop->1 -> packet drains, sync_err stays 1.
//  6. Reset in SEND2 -> outputs clear on the rst edge; after release, next pair drains normally, pkt_count restarts at 1.

Source files
------------

// File: rtl/pea_result_drain.sv
// Drains paired result/status FIFOs of the PEA output stage and serializes each
// pair as four host words (status hi/lo, result hi/lo) over valid/ready.
module pea_result_drain #(
  parameter int unsigned buffer_size_out = 32,
  parameter int unsigned width           = 16,
  localparam int unsigned pop_w          = $clog2(buffer_size_out)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [pop_w-1:0]   result_pop,
  input  logic [pop_w-1:0]   status_pop,
  input  logic [2*width-1:0] result_in,
  input  logic [2*width-1:0] status_in,
  output logic               rd_en,
  output logic [width-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        pkt_count,
  output logic [15:0]        err_count,
  output logic               sync_err,
  output logic               busy
);

  typedef enum logic [2:0] {
    StIdle, StPop, StLatch, StSend0, StSend1, StSend2, StSend3
  } state_e;

  state_e             state_q, state_d;
  logic [2*width-1:0] res_q, res_d;
  logic [2*width-1:0] sts_q, sts_d;
  logic [width-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        pkt_q, pkt_d;
  logic [15:0]        err_q, err_d;
  logic               sync_q, sync_d;

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    sts_d       = sts_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    pkt_d       = pkt_q;
    err_d       = err_q;
    sync_d      = sync_q;
    unique case (state_q)
      StIdle: begin
        if (result_pop != status_pop) sync_d = 1'b1;
        // Only pop when both sides hold an entry, so the pair stays aligned.
        if (result_pop != '0 && status_pop != '0) state_d = StPop;
      end
      StPop:   state_d = StLatch;
      StLatch: begin
        res_d = result_in;
        sts_d = status_in;
        if (status_in != '0 && err_q != 16'hFFFF) err_d = err_q + 16'd1;
        out_data_d  = status_in[2*width-1:width];
        out_valid_d = 1'b1;
        state_d     = StSend0;
      end
      // out_valid_q is high in every send state, so out_ready alone marks the handshake.
      StSend0: if (out_ready) begin
        out_data_d = sts_q[width-1:0];
        state_d    = StSend1;
      end
      StSend1: if (out_ready) begin
        out_data_d = res_q[2*width-1:width];
        state_d    = StSend2;
      end
      StSend2: if (out_ready) begin
        out_data_d = res_q[width-1:0];
        state_d    = StSend3;
      end
      StSend3: if (out_ready) begin
        out_valid_d = 1'b0;
        pkt_d       = pkt_q + 16'd1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      res_q       <= '0;
      sts_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pkt_q       <= '0;
      err_q       <= '0;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      sts_q       <= sts_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pkt_q       <= pkt_d;
      err_q       <= err_d;
      sync_q      <= sync_d;
    end
  end

  assign rd_en     = (state_q == StPop);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pkt_count = pkt_q;
  assign err_count = err_q;
  assign sync_err  = sync_q;

endmodule
